prog_mem_responder: RTL and testbench
=====================================

PROG_MEM_RESPONDER -- requirements
Module: prog_mem_responder

Interface
REQ-001 SHALL have parameter OP_CODE_SIZE, default 4, opcode field width.
REQ-002 SHALL have parameter INSTRUCTION_SIZE, default OP_CODE_SIZE+24, instruction word width.
REQ-003 SHALL have parameter ROM_DEPTH, default 256, program word count; AW = $clog2(ROM_DEPTH).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have i_reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have i_load_start  input  1  one-cycle pulse that begins a program load.
REQ-007 SHALL have i_load_valid  input  1  load word present; i_load_data  input  INSTRUCTION_SIZE  load word.
REQ-008 SHALL have i_load_last  input  1  qualifies the final load word.
REQ-009 SHALL have o_load_ready  output  1  high while words are accepted.
REQ-010 SHALL have i_req  input  1  fetch request from the processor; i_prog_counter  input  AW  fetch address.
REQ-011 SHALL have o_instruction  output  INSTRUCTION_SIZE  fetched word; o_instr_valid  output  1  fetch response strobe.
REQ-012 SHALL have o_addr_err  output  1  fetch beyond program length; o_ready  output  1  program loaded and fetchable.
REQ-013 SHALL have o_prog_len  output  AW+1  number of loaded words; o_load_full  output  1  load truncated at ROM_DEPTH.

Function
REQ-014 SHALL implement FSM EMPTY, LOADING, READY; o_ready = (state==READY); o_load_ready = (state==LOADING).
REQ-015 SHALL move EMPTY or READY -> LOADING on i_load_start, clearing write pointer, o_prog_len and o_load_full.
REQ-016 SHALL ignore i_load_start while LOADING.
REQ-017 SHALL, in LOADING with i_load_valid, write i_load_data to mem[pointer] and increment pointer and o_prog_len.
REQ-018 SHALL go LOADING -> READY in the cycle after the word written with i_load_last=1.
REQ-019 SHALL, when the word at address ROM_DEPTH-1 is written without i_load_last, go READY and set o_load_full (sticky until next i_load_start).
REQ-020 SHALL ignore i_load_valid outside LOADING.
REQ-021 SHALL, for i_req sampled in READY, drive o_instr_valid=1 for exactly one cycle on the next edge with o_instruction = mem[i_prog_counter] (latency 1, back-to-back every cycle).
REQ-022 SHALL, when i_prog_counter >= o_prog_len, return o_instruction = 0 and pulse o_addr_err together with o_instr_valid.
REQ-023 SHALL ignore i_req in EMPTY or LOADING: no o_instr_valid, o_instruction holds its value.
REQ-024 SHALL, when i_req and i_load_start coincide in READY, serve the fetch (response next cycle) and enter LOADING.
REQ-025 SHALL hold o_instruction between responses; o_instr_valid and o_addr_err are low otherwise.
REQ-026 SHALL implement storage as a synchronous-read array of ROM_DEPTH x INSTRUCTION_SIZE.

Reset
REQ-027 SHALL on i_reset asynchronously set state EMPTY, pointer 0, o_prog_len 0, o_load_full 0, o_instruction 0, o_instr_valid 0, o_addr_err 0.
REQ-028 SHALL leave memory contents uncleared; reset mid-load discards the partial program (o_prog_len 0).

Configuration
REQ-029 SHALL, with PROG_MEM_FETCH_CNT_EN defined, add output o_fetch_count (16 bits) counting o_instr_valid pulses, saturating at 0xFFFF, cleared by reset and i_load_start.
REQ-030 SHALL, without PROG_MEM_FETCH_CNT_EN, omit o_fetch_count and its logic entirely.

Verification
REQ-031 SHALL cover: reset, load 3 words 0x1000001,0x2000002,0x3000003 (last on 3rd) -> o_ready=1, o_prog_len=3.
REQ-032 SHALL cover: i_req with pc=1,2,0 on consecutive cycles -> o_instruction 0x2000002,0x3000003,0x1000001 each 1 cycle later, o_instr_valid high 3 cycles.
REQ-033 SHALL cover: i_req pc=5 with o_prog_len=3 -> o_instruction=0, o_addr_err=1, o_instr_valid=1 one cycle.
REQ-034 SHALL cover: 256 words loaded without i_load_last -> o_load_full=1, o_prog_len=256, state READY.
REQ-035 SHALL cover: i_reset asserted after 2 load words -> o_ready=0, o_prog_len=0 immediately; i_req ignored.
REQ-036 SHALL cover: with PROG_MEM_FETCH_CNT_EN, 4 fetches -> o_fetch_count=4; i_load_start -> 0.

Source files
------------

// File: rtl/prog_mem_responder.sv
// Program memory: streams a program in through a load port, then answers
// one-cycle-latency fetches. Define PROG_MEM_FETCH_CNT_EN to add o_fetch_count.
module prog_mem_responder #(
  parameter int OP_CODE_SIZE     = 4,
  parameter int INSTRUCTION_SIZE = OP_CODE_SIZE + 24,
  parameter int ROM_DEPTH        = 256,
  localparam int AW              = $clog2(ROM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic                        i_load_start,
  input  logic                        i_load_valid,
  input  logic [INSTRUCTION_SIZE-1:0] i_load_data,
  input  logic                        i_load_last,
  output logic                        o_load_ready,
  input  logic                        i_req,
  input  logic [AW-1:0]               i_prog_counter,
  output logic [INSTRUCTION_SIZE-1:0] o_instruction,
  output logic                        o_instr_valid,
  output logic                        o_addr_err,
  output logic                        o_ready,
  output logic [AW:0]                 o_prog_len,
  output logic                        o_load_full
`ifdef PROG_MEM_FETCH_CNT_EN
  ,
  output logic [15:0]                 o_fetch_count
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [AW-1:0]               r_wr_ptr;
  logic [AW:0]                 r_prog_len;
  logic                        r_load_full;
  logic [INSTRUCTION_SIZE-1:0] r_instruction;
  logic                        r_instr_valid;
  logic                        r_addr_err;
  logic [INSTRUCTION_SIZE-1:0] r_mem [ROM_DEPTH];

  logic w_load_accept;
  logic w_write;
  logic w_ptr_at_end;
  logic w_set_full;
  logic w_fetch;
  logic w_in_range;

  assign w_load_accept = i_load_start && (r_state != ST_LOADING);
  assign w_write       = i_load_valid && (r_state == ST_LOADING);
  assign w_ptr_at_end  = (r_wr_ptr == AW'(ROM_DEPTH - 1));
  assign w_set_full    = w_write && !i_load_last && w_ptr_at_end;
  assign w_fetch       = i_req && (r_state == ST_READY);
  assign w_in_range    = ({1'b0, i_prog_counter} < r_prog_len);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (i_load_start) w_state_next = ST_LOADING;
      end
      ST_LOADING: begin
        if (w_write && (i_load_last || w_ptr_at_end)) w_state_next = ST_READY;
      end
      ST_READY: begin
        if (i_load_start) w_state_next = ST_LOADING;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_prog_len  <= '0;
      r_load_full <= 1'b0;
    end else if (w_load_accept) begin
      r_wr_ptr    <= '0;
      r_prog_len  <= '0;
      r_load_full <= 1'b0;
    end else if (w_write) begin
      r_wr_ptr   <= r_wr_ptr + AW'(1);
      r_prog_len <= r_prog_len + (AW+1)'(1);
      if (w_set_full) r_load_full <= 1'b1;
    end
  end

  // Storage is not reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= i_load_data;
  end

  // Fetch uses the pre-load length, so a fetch coinciding with a new load
  // is answered from the old program.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      r_instr_valid <= w_fetch;
      r_addr_err    <= w_fetch && !w_in_range;
      if (w_fetch) r_instruction <= w_in_range ? r_mem[i_prog_counter] : '0;
    end
  end

`ifdef PROG_MEM_FETCH_CNT_EN
  logic [15:0] r_fetch_count;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_fetch_count <= '0;
    end else if (w_load_accept) begin
      r_fetch_count <= '0;
    end else if (r_instr_valid && (r_fetch_count != '1)) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`endif

  assign o_load_ready  = (r_state == ST_LOADING);
  assign o_ready       = (r_state == ST_READY);
  assign o_prog_len    = r_prog_len;
  assign o_load_full   = r_load_full;
  assign o_instruction = r_instruction;
  assign o_instr_valid = r_instr_valid;
  assign o_addr_err    = r_addr_err;

endmodule

// File: tb/tb_prog_mem_responder.sv
// Randomized bench for prog_mem_responder against a behavioural program-memory model.
module tb_prog_mem_responder;

  localparam int IW    = 28;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_load_start;
  logic          i_load_valid;
  logic [IW-1:0] i_load_data;
  logic          i_load_last;
  logic          o_load_ready;
  logic          i_req;
  logic [AW-1:0] i_prog_counter;
  logic [IW-1:0] o_instruction;
  logic          o_instr_valid;
  logic          o_addr_err;
  logic          o_ready;
  logic [AW:0]   o_prog_len;
  logic          o_load_full;
`ifdef PROG_MEM_FETCH_CNT_EN
  logic [15:0]   o_fetch_count;
`endif

  int vectors    = 0;
  int miscompares = 0;

  prog_mem_responder #(
    .OP_CODE_SIZE(4),
    .INSTRUCTION_SIZE(IW),
    .ROM_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .i_reset(i_reset),
    .i_load_start(i_load_start),
    .i_load_valid(i_load_valid),
    .i_load_data(i_load_data),
    .i_load_last(i_load_last),
    .o_load_ready(o_load_ready),
    .i_req(i_req),
    .i_prog_counter(i_prog_counter),
    .o_instruction(o_instruction),
    .o_instr_valid(o_instr_valid),
    .o_addr_err(o_addr_err),
    .o_ready(o_ready),
    .o_prog_len(o_prog_len),
    .o_load_full(o_load_full)
`ifdef PROG_MEM_FETCH_CNT_EN
    ,
    .o_fetch_count(o_fetch_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: "loading"/"loaded" flags plus a word list.
  bit          m_loading, m_loaded, m_full, m_valid, m_err;
  int          m_len;
  int          m_cnt;
  logic [IW-1:0] m_instr;
  logic [IW-1:0] m_mem [DEPTH];

  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      m_loading = 0; m_loaded = 0; m_full = 0; m_valid = 0; m_err = 0;
      m_len = 0; m_cnt = 0; m_instr = '0;
    end else begin
      bit accept;
      accept = i_load_start && !m_loading;
      if (m_valid && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (i_req && m_loaded) begin
        m_valid = 1;
        if (int'(i_prog_counter) < m_len) begin
          m_instr = m_mem[i_prog_counter]; m_err = 0;
        end else begin
          m_instr = '0; m_err = 1;
        end
      end else begin
        m_valid = 0; m_err = 0;
      end
      if (accept) begin
        m_loading = 1; m_loaded = 0; m_len = 0; m_full = 0; m_cnt = 0;
      end else if (m_loading && i_load_valid) begin
        m_mem[m_len] = i_load_data;
        m_len = m_len + 1;
        if (i_load_last) begin
          m_loading = 0; m_loaded = 1;
        end else if (m_len == DEPTH) begin
          m_loading = 0; m_loaded = 1; m_full = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!i_reset) begin
      bit bad;
      bad = (o_ready !== m_loaded) || (o_load_ready !== m_loading) ||
            (o_prog_len !== (AW+1)'(m_len)) || (o_load_full !== m_full) ||
            (o_instr_valid !== m_valid) || (o_addr_err !== m_err) ||
            (o_instruction !== m_instr);
`ifdef PROG_MEM_FETCH_CNT_EN
      bad = bad || (o_fetch_count !== 16'(m_cnt));
`endif
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL cycle t=%0t got rdy=%b lrdy=%b len=%0d full=%b v=%b err=%b ins=%h expected rdy=%b lrdy=%b len=%0d full=%b v=%b err=%b ins=%h",
                 $time, o_ready, o_load_ready, o_prog_len, o_load_full, o_instr_valid, o_addr_err, o_instruction,
                 m_loaded, m_loading, m_len, m_full, m_valid, m_err, m_instr);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_load_start = 0; i_load_valid = 0; i_load_last = 0; i_load_data = '0;
    i_req = 0; i_prog_counter = '0;
  endtask

  task automatic do_reset();
    i_reset = 1;
    tick();
    tick();
    i_reset = 0;
  endtask

  task automatic start_load();
    i_load_start = 1;
    tick();
    i_load_start = 0;
  endtask

  task automatic load_word(input logic [IW-1:0] d, input logic last);
    i_load_valid = 1; i_load_data = d; i_load_last = last;
    tick();
    i_load_valid = 0; i_load_last = 0;
  endtask

  task automatic fetch(input int pc);
    i_req = 1; i_prog_counter = AW'(pc);
    tick();
  endtask

  initial begin
    i_reset = 1;
    idle_inputs();
    tick();
    do_reset();
    check("reset_ready", 64'(o_ready), 64'd0);
    check("reset_len", 64'(o_prog_len), 64'd0);
    check("reset_valid", 64'(o_instr_valid), 64'd0);
    check("reset_instr", 64'(o_instruction), 64'd0);
    check("reset_load_ready", 64'(o_load_ready), 64'd0);

    start_load();
    check("loading_ready", 64'(o_load_ready), 64'd1);
    load_word(28'h1000001, 0);
    load_word(28'h2000002, 0);
    load_word(28'h3000003, 1);
    check("load3_ready", 64'(o_ready), 64'd1);
    check("load3_len", 64'(o_prog_len), 64'd3);

    fetch(1);
    check("fetch1", 64'(o_instruction), 64'h2000002);
    check("fetch1_valid", 64'(o_instr_valid), 64'd1);
    fetch(2);
    check("fetch2", 64'(o_instruction), 64'h3000003);
    check("fetch2_valid", 64'(o_instr_valid), 64'd1);
    fetch(0);
    check("fetch0", 64'(o_instruction), 64'h1000001);
    check("fetch0_valid", 64'(o_instr_valid), 64'd1);
    i_req = 0;
    tick();
    check("idle_valid", 64'(o_instr_valid), 64'd0);
    check("idle_hold", 64'(o_instruction), 64'h1000001);

    fetch(5);
    check("oob_instr", 64'(o_instruction), 64'd0);
    check("oob_err", 64'(o_addr_err), 64'd1);
    check("oob_valid", 64'(o_instr_valid), 64'd1);
    i_req = 0;
    tick();
    check("oob_err_drop", 64'(o_addr_err), 64'd0);

    start_load();
    for (int i = 0; i < DEPTH; i++) load_word(IW'($urandom), 0);
    check("full_flag", 64'(o_load_full), 64'd1);
    check("full_len", 64'(o_prog_len), 64'd256);
    check("full_ready", 64'(o_ready), 64'd1);
    fetch(255);
    check("full_last_word", 64'(o_instruction), 64'(m_mem[255]));
    i_req = 0;

    start_load();
    load_word(28'hAAAAAAA, 0);
    load_word(28'hBBBBBBB, 0);
    #2 i_reset = 1;
    #1;
    check("midreset_ready", 64'(o_ready), 64'd0);
    check("midreset_len", 64'(o_prog_len), 64'd0);
    check("midreset_loadready", 64'(o_load_ready), 64'd0);
    @(posedge clk);
    #1 i_reset = 0;
    fetch(0);
    check("midreset_req_ignored", 64'(o_instr_valid), 64'd0);
    i_req = 0;

`ifdef PROG_MEM_FETCH_CNT_EN
    start_load();
    load_word(28'h1000001, 1);
    for (int i = 0; i < 4; i++) fetch(i);
    i_req = 0;
    tick();
    check("fetch_count4", 64'(o_fetch_count), 64'd4);
    start_load();
    check("fetch_count_clr", 64'(o_fetch_count), 64'd0);
`endif

    for (int c = 0; c < 4000; c++) begin
      i_load_start   = ($urandom_range(0, 99) < 2);
      i_load_valid   = ($urandom_range(0, 99) < 70);
      i_load_last    = ($urandom_range(0, 99) < 8);
      i_load_data    = IW'($urandom);
      i_req          = ($urandom_range(0, 99) < 60);
      i_prog_counter = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 499) == 0) begin
        #2 i_reset = 1;
        @(posedge clk);
        #1 i_reset = 0;
      end else begin
        tick();
      end
    end
    idle_inputs();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
